func_sweep_checker: RTL and testbench
=====================================

Name: func_sweep_checker

Overview:
- Sequential stimulus-and-check stage wrapped around the 4-input function F(w,x,y,z) = wx' + y'z' + w'z'.
- Drives w,x,y,z through all 16 combinations and samples the three implementations (original, NOR-only, NAND-only) after a settle window.
- Compares each implementation against an internal golden model and reports pass/fail, mismatch count, first failing vector and captured truth table.
- Replaces the hand-written #10 stimulus sequence with a synthesizable, clocked self-test.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low; one clock; polarity and synchronicity fixed
start  input  1  one-cycle (or level) request to begin a sweep
w  output  1  stimulus bit 3 (MSB of vector)
x  output  1  stimulus bit 2
y  output  1  stimulus bit 1
z  output  1  stimulus bit 0
f_original  input  1  response of original implementation
f_nor  input  1  response of NOR implementation
f_nand  input  1  response of NAND implementation
busy  output  1  sweep in progress
done  output  1  sweep complete, results valid; held until next accepted start
pass  output  1  done && mismatch_count==0
mismatch_count  output  5  number of vectors (0..16) where any implementation differs from golden
fail_mask  output  3  sticky per-implementation fail flags: [0] original, [1] nor, [2] nand
first_fail_vec  output  4  {w,x,y,z} of first failing vector
first_fail_valid  output  1  first_fail_vec holds a real value
truth_table  output  16  bit i = f_original sampled at vector i

Behaviour:
- Reset (rst_n==0 at clk edge, any state, including mid-sweep): state=IDLE; w,x,y,z=0; busy, done, pass, first_fail_valid=0; mismatch_count=0; fail_mask=0; first_fail_vec=0; truth_table=0.
- Vector register vec[3:0] drives {w,x,y,z} directly from a flop; no combinational path from any input to any output.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> SETTLE. On the same edge: vec=0; settle counter=SETTLE_CYCLES-1; all result registers cleared; busy=1.
- SETTLE: counter decrements each cycle. Counter==0 -> SAMPLE.
- SAMPLE (one cycle):
  - Compute golden g = F(vec).
  - Set err bits e[k] = (f_k != g).
  - Write truth_table[vec] = f_original.
  - fail_mask |= e.
  - If |e: mismatch_count += 1; if first_fail_valid==0, capture first_fail_vec=vec and set first_fail_valid=1.
  - vec==15 -> DONE (busy=0, done=1, pass=(final count==0)).
  - Otherwise vec+=1, reload counter, -> SETTLE.
- Each vector occupies SETTLE_CYCLES+1 cycles. done rises 16*(SETTLE_CYCLES+1) edges after the edge that accepted start (48 for default).
- start while busy: ignored; sweep continues unchanged.
- DONE: outputs held; w,x,y,z stay at 4'hF. start=1 -> behaves exactly as start in IDLE (results cleared, new sweep).
- mismatch_count is 5 bits; max value is 16, so no saturation is required.
- vec wraps only by transition to DONE; it is never incremented past 15.
- Golden truth table constant = 16'h1F55 (F=1 at vectors 0,2,4,6,8,9,10,11,12).

Decomposition:
- Package func_sweep_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - NUM_VECTORS=16
  - GOLDEN_TT=16'h1F55
  - IMPL_ORIG=0, IMPL_NOR=1, IMPL_NAND=2 (fail_mask bit indices)
- One sub-module: golden_func_ref, a combinational 4-in/1-out model of F; used by the checker and reusable by other benches.
- Settle counter and FSM stay in the top module.

Test Plan:
1. Reset, connect the three real implementations, pulse start -> done exactly 48 cycles later; pass=1; mismatch_count=0; fail_mask=3'b000; truth_table=16'h1F55; first_fail_valid=0.
2. Tie f_nor=0, others correct -> mismatch_count=9; fail_mask=3'b010; first_fail_vec=4'h0; pass=0.
3. Inject fault: f_nand inverted only when {w,x,y,z}=4'hB -> mismatch_count=1; fail_mask=3'b100; first_fail_vec=4'hB; truth_table=16'h1F55.
4. Assert start again at cycle 20 of an active sweep -> ignored; vector sequence 0..15 unchanged; done still at cycle 48.
5. Drive rst_n=0 for one edge at cycle 25 -> next cycle busy=0, {w,x,y,z}=0, all results 0; a new start completes a clean sweep in 48 cycles.
6. Set SETTLE_CYCLES=1 -> done after 32 cycles. Hold start high in DONE -> results cleared next edge and a new sweep runs; done reasserts 32 cycles later.

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and constants for the F(w,x,y,z) = wx' + y'z' + w'z' sweep checker.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          NUM_VECTORS = 16;
  localparam logic [15:0] GOLDEN_TT   = 16'h1F55;

  // Bit positions inside fail_mask and the per-sample error vector.
  localparam int IMPL_ORIG = 0;
  localparam int IMPL_NOR  = 1;
  localparam int IMPL_NAND = 2;

  localparam logic [3:0] LAST_VEC = 4'(NUM_VECTORS - 1);

endpackage

// File: rtl/func_sweep_checker_golden.sv
// Combinational reference model of F(w,x,y,z) = wx' + y'z' + w'z'.
module golden_func_ref (
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic f
);

  assign f = (w & ~x) | (~y & ~z) | (~w & ~z);

endmodule

// File: rtl/func_sweep_checker.sv
// Clocked self-test: sweeps {w,x,y,z} through all 16 vectors, samples three
// implementations after a settle window and checks them against the golden model.
module func_sweep_checker
  import func_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  input  logic        f_original,
  input  logic        f_nor,
  input  logic        f_nand,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [2:0]  fail_mask,
  output logic [3:0]  first_fail_vec,
  output logic        first_fail_valid,
  output logic [15:0] truth_table
);

  // Legal SETTLE_CYCLES is 1..15, so the reload value always fits in 4 bits.
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] vec;
  logic [3:0] settle_cnt;
  logic       golden;
  logic [2:0] err;
  logic       any_err;
  logic [4:0] count_next;

  golden_func_ref u_golden (
    .w (vec[3]),
    .x (vec[2]),
    .y (vec[1]),
    .z (vec[0]),
    .f (golden)
  );

  // Stimulus comes straight from the vector flop, never from an input.
  assign w = vec[3];
  assign x = vec[2];
  assign y = vec[1];
  assign z = vec[0];

  always_comb begin
    err            = 3'b000;
    err[IMPL_ORIG] = (f_original != golden);
    err[IMPL_NOR]  = (f_nor      != golden);
    err[IMPL_NAND] = (f_nand     != golden);
    any_err        = |err;
    count_next     = any_err ? (mismatch_count + 5'd1) : mismatch_count;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_next = SAMPLE;
      end
      SAMPLE: begin
        state_next = (vec == LAST_VEC) ? DONE : SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= 4'd0;
      settle_cnt       <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= 5'd0;
      fail_mask        <= 3'b000;
      first_fail_vec   <= 4'd0;
      first_fail_valid <= 1'b0;
      truth_table      <= 16'd0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE, DONE: begin
          // A start here begins a fresh sweep with every result cleared.
          if (start) begin
            vec              <= 4'd0;
            settle_cnt       <= SETTLE_RELOAD;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= 5'd0;
            fail_mask        <= 3'b000;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
            truth_table      <= 16'd0;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          truth_table[vec] <= f_original;
          fail_mask        <= fail_mask | err;
          mismatch_count   <= count_next;
          if (any_err && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (vec == LAST_VEC) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (count_next == 5'd0);
          end else begin
            vec        <= vec + 4'd1;
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Bench for func_sweep_checker: table of fault configurations plus hand-written
// sequences for restart-while-busy, mid-sweep reset and a short settle window.
module tb_func_sweep_checker;

  typedef struct {
    string       name;
    logic [15:0] orig_inv;
    logic        nor_zero;
    logic [15:0] nor_inv;
    logic [15:0] nand_inv;
    logic        exp_pass;
    logic [4:0]  exp_count;
    logic [2:0]  exp_mask;
    logic [3:0]  exp_ffv;
    logic        exp_ffvalid;
    logic [15:0] exp_tt;
  } vec_t;

  // Packed expectation: {pass, count[4:0], mask[2:0], ffv[3:0], ffvalid, tt[15:0]}
  logic [29:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;
  logic [15:0] orig_inv, nor_inv, nand_inv;
  logic nor_zero, nor_zero_b;

  logic wa, xa, ya, za, fo_a, fnr_a, fnd_a, busy_a, done_a, pass_a, ffval_a;
  logic [4:0] cnt_a;
  logic [2:0] mask_a;
  logic [3:0] ffv_a, va;
  logic [15:0] tt_a;

  logic wb, xb, yb, zb, fo_b, fnr_b, fnd_b, busy_b, done_b, pass_b, ffval_b;
  logic [4:0] cnt_b;
  logic [2:0] mask_b;
  logic [3:0] ffv_b, vb;
  logic [15:0] tt_b;

  function automatic logic f_sop(input logic [3:0] v);
    return (v[3] & ~v[2]) | (~v[1] & ~v[0]) | (~v[3] & ~v[0]);
  endfunction

  function automatic logic f_nor_impl(input logic [3:0] v);
    logic a, b, c, n;
    a = ~(~v[3] | v[2]);
    b = ~(v[1] | v[0]);
    c = ~(v[3] | v[0]);
    n = ~(a | b | c);
    return ~(n | n);
  endfunction

  function automatic logic f_nand_impl(input logic [3:0] v);
    logic a, b, c;
    a = ~(v[3] & ~v[2]);
    b = ~(~v[1] & ~v[0]);
    c = ~(~v[3] & ~v[0]);
    return ~(a & b & c);
  endfunction

  assign va = {wa, xa, ya, za};
  assign vb = {wb, xb, yb, zb};

  always_comb begin
    fo_a  = f_sop(va) ^ orig_inv[va];
    fnr_a = nor_zero ? 1'b0 : (f_nor_impl(va) ^ nor_inv[va]);
    fnd_a = f_nand_impl(va) ^ nand_inv[va];
    fo_b  = f_sop(vb);
    fnr_b = nor_zero_b ? 1'b0 : f_nor_impl(vb);
    fnd_b = f_nand_impl(vb);
  end

  func_sweep_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .w(wa), .x(xa), .y(ya), .z(za),
    .f_original(fo_a), .f_nor(fnr_a), .f_nand(fnd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_count(cnt_a), .fail_mask(mask_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a),
    .truth_table(tt_a)
  );

  func_sweep_checker #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .w(wb), .x(xb), .y(yb), .z(zb),
    .f_original(fo_b), .f_nor(fnr_b), .f_nand(fnd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_count(cnt_b), .fail_mask(mask_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b),
    .truth_table(tt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [4:0] c, input logic [2:0] m,
                          input logic [3:0] fv, input logic fvl, input logic [15:0] tt);
    exp_q.push_back({p, c, m, fv, fvl, tt});
  endtask

  // Pulse start on dut_a, then count edges from the accepting edge until done.
  task automatic sweep_a(output int lat);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic compare_a(input string tag);
    logic [29:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: got empty expected queue, required one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_done"},    32'(done_a),  32'd1);
      check({tag, "_pass"},    32'(pass_a),  32'(e[29]));
      check({tag, "_count"},   32'(cnt_a),   32'(e[28:24]));
      check({tag, "_mask"},    32'(mask_a),  32'(e[23:21]));
      check({tag, "_ffv"},     32'(ffv_a),   32'(e[20:17]));
      check({tag, "_ffvalid"}, 32'(ffval_a), 32'(e[16]));
      check({tag, "_tt"},      32'(tt_a),    32'(e[15:0]));
      check({tag, "_busy"},    32'(busy_a),  32'd0);
    end
  endtask

  task automatic set_clean();
    orig_inv = 16'h0; nor_inv = 16'h0; nand_inv = 16'h0; nor_zero = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    int lat;
    int cyc;
    int ev;

    tbl[0] = '{"clean",     16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'd0, 3'b000, 4'h0, 1'b0, 16'h1F55};
    tbl[1] = '{"nor_zero",  16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 5'd9, 3'b010, 4'h0, 1'b1, 16'h1F55};
    tbl[2] = '{"nand_at_b", 16'h0000, 1'b0, 16'h0000, 16'h0800, 1'b0, 5'd1, 3'b100, 4'hB, 1'b1, 16'h1F55};
    tbl[3] = '{"orig_at_5", 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'd1, 3'b001, 4'h5, 1'b1, 16'h1F75};
    tbl[4] = '{"multi",     16'h4000, 1'b0, 16'h0008, 16'h0008, 1'b0, 5'd2, 3'b111, 4'h3, 1'b1, 16'h5F55};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; nor_zero_b = 1'b0;
    set_clean();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    check("rst_pass",  32'(pass_a),  32'd0);
    check("rst_vec",   32'(va),      32'd0);
    check("rst_count", 32'(cnt_a),   32'd0);
    check("rst_mask",  32'(mask_a),  32'd0);
    check("rst_ffv",   32'(ffv_a),   32'd0);
    check("rst_ffval", 32'(ffval_a), 32'd0);
    check("rst_tt",    32'(tt_a),    32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      orig_inv = tbl[i].orig_inv;
      nor_zero = tbl[i].nor_zero;
      nor_inv  = tbl[i].nor_inv;
      nand_inv = tbl[i].nand_inv;
      push_exp(tbl[i].exp_pass, tbl[i].exp_count, tbl[i].exp_mask,
               tbl[i].exp_ffv, tbl[i].exp_ffvalid, tbl[i].exp_tt);
      sweep_a(lat);
      check({tbl[i].name, "_latency"}, 32'(lat), 32'd48);
      compare_a(tbl[i].name);
      repeat (2) @(posedge clk);
      #1;
    end

    // Start re-asserted mid-sweep must not disturb the vector sequence.
    set_clean();
    push_exp(1'b1, 5'd0, 3'b000, 4'h0, 1'b0, 16'h1F55);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      ev = (cyc / 3 > 15) ? 15 : cyc / 3;
      if (cyc <= 48) begin
        check($sformatf("restart_vec_c%0d", cyc), 32'(va), 32'(ev));
        check($sformatf("restart_busy_c%0d", cyc), 32'(busy_a), 32'(cyc < 48));
      end
      if (done_a) break;
      if (cyc == 19) start_a = 1'b1;
      if (cyc == 20) start_a = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    check("restart_latency", 32'(cyc), 32'd48);
    compare_a("restart");
    @(posedge clk); #1;

    // Reset mid-sweep, then a clean sweep from scratch.
    nor_zero = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (cyc < 24) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy",  32'(busy_a),  32'd0);
    check("midrst_done",  32'(done_a),  32'd0);
    check("midrst_vec",   32'(va),      32'd0);
    check("midrst_count", 32'(cnt_a),   32'd0);
    check("midrst_mask",  32'(mask_a),  32'd0);
    check("midrst_ffval", 32'(ffval_a), 32'd0);
    check("midrst_ffv",   32'(ffv_a),   32'd0);
    check("midrst_tt",    32'(tt_a),    32'd0);
    check("midrst_pass",  32'(pass_a),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_vec_hold", 32'(va), 32'd0);
    set_clean();
    push_exp(1'b1, 5'd0, 3'b000, 4'h0, 1'b0, 16'h1F55);
    sweep_a(lat);
    check("postrst_latency", 32'(lat), 32'd48);
    compare_a("postrst");
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(done_a), 32'd1);
    check("done_vec_f", 32'(va), 32'hF);

    // Short settle window; start held high while DONE restarts the sweep.
    nor_zero_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b_latency", 32'(lat), 32'd32);
    check("b_count",   32'(cnt_b), 32'd9);
    check("b_mask",    32'(mask_b), 32'b010);
    check("b_pass",    32'(pass_b), 32'd0);
    nor_zero_b = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    check("b_restart_done",  32'(done_b),  32'd0);
    check("b_restart_busy",  32'(busy_b),  32'd1);
    check("b_restart_count", 32'(cnt_b),   32'd0);
    check("b_restart_mask",  32'(mask_b),  32'd0);
    check("b_restart_ffval", 32'(ffval_b), 32'd0);
    check("b_restart_vec",   32'(vb),      32'd0);
    cyc = 0;
    while (!done_b && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    start_b = 1'b0;
    check("b2_latency", 32'(cyc), 32'd32);
    check("b2_pass",    32'(pass_b), 32'd1);
    check("b2_count",   32'(cnt_b), 32'd0);
    check("b2_tt",      32'(tt_b), 32'h1F55);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
